image_frame_loader: RTL
=======================

# image_frame_loader

Front-end frame buffer for the Sobel datapath, the writer side of the image-memory read port. It accepts a raster-ordered pixel stream over a valid/ready handshake and stores one full frame. When the frame is complete it pulses `start` to the Sobel engine and serves random-access `(row, col) -> pixel` reads. It holds the frame until the consumer releases it. Single-buffered: no new frame is accepted while a frame is held.

## Interface
- `IMG_WIDTH`, default 8: pixels per row.
- `IMG_HEIGHT`, default 8: rows per frame.
- `DATA_WIDTH`, default 8: bits per pixel.
- Local `COL_W = $clog2(IMG_WIDTH)` and `ROW_W = $clog2(IMG_HEIGHT)`; both are 3 at defaults.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  loader can accept a beat.
- `in_data`  in  DATA_WIDTH  pixel value.
- `in_sof`  in  1  beat is pixel (0,0) of a new frame.
- `rd_row`  in  ROW_W  read row address.
- `rd_col`  in  COL_W  read column address.
- `rd_pixel`  out  DATA_WIDTH  combinational read data.
- `frame_ready`  out  1  a complete frame is held and valid to read.
- `start`  out  1  one-cycle pulse when a frame completes.
- `frame_release`  in  1  consumer is finished with the frame.
- `sof_err`  out  1  one-cycle pulse on a framing error.

## Operation
- A beat is accepted when `in_valid & in_ready`. Beats that are not accepted have no effect.
- FSM states are IDLE, LOAD and FULL. Reset state is IDLE, with write pointers `wr_row = 0` and `wr_col = 0`.
- IDLE:
  - `in_ready = 1`.
  - Accepted beat with `in_sof = 1`: write to (0,0), set `wr_col = 1`, go to LOAD.
  - Accepted beat with `in_sof = 0`: drop the beat, pulse `sof_err`, stay in IDLE.
- LOAD:
  - `in_ready = 1`.
  - Accepted beat with `in_sof = 0`: write to (`wr_row`, `wr_col`), then advance the pointer. `wr_col` wraps to 0 after `IMG_WIDTH-1` and `wr_row` then increments.
  - Accepted beat with `in_sof = 1`: the current frame is truncated. Pulse `sof_err`, write the beat to (0,0), set pointers to (0,1), stay in LOAD.
  - Accepted beat written to (`IMG_HEIGHT-1`, `IMG_WIDTH-1`): go to FULL and clear the pointers.
- FULL:
  - `in_ready = 0` and `frame_ready = 1`.
  - `frame_release = 1` moves to IDLE on the next edge.
  - `frame_release` is ignored in IDLE and LOAD.
- Degenerate case: if `IMG_WIDTH * IMG_HEIGHT == 1`, the accepted `in_sof` beat in IDLE goes directly to FULL.
- Read port:
  - `rd_pixel = mem[rd_row*IMG_WIDTH + rd_col]`, combinational, readable in any state.
  - Contents are stable only in FULL.
  - Out-of-range addresses (`rd_row >= IMG_HEIGHT` or `rd_col >= IMG_WIDTH`) return 0.
- Memory contents are not reset. `in_data` is stored unmodified.

## Timing
- Reset values: `in_ready = 1` (IDLE), `frame_ready = 0`, `start = 0`, `sof_err = 0`. `rd_pixel` follows memory and is undefined until written.
- A write becomes visible on `rd_pixel` in the cycle after the accepting edge.
- `start` and `frame_ready` both rise in the cycle after the final beat is accepted. `start` is high for exactly 1 cycle per completed frame.
- `sof_err` is registered and high for 1 cycle, in the cycle after the offending beat.
- `in_ready` is combinational from state only, never from `in_valid`. It falls in the same cycle `frame_ready` rises.
- Release timing: `frame_release` high at edge N gives IDLE after edge N and `in_ready = 1` from cycle N+1. A new `in_sof` beat is accepted at edge N+1 at the earliest.
- Reset asserted mid-LOAD or in FULL: asynchronous return to IDLE. The partial frame is discarded, no `start` is generated, and pending pulses clear immediately.
- Throughput is 1 pixel per cycle in LOAD. Frame fill latency is `IMG_WIDTH * IMG_HEIGHT` accepted beats.

## Structure
- `sobel_pkg` holds the shared defaults `IMG_WIDTH`, `IMG_HEIGHT` and `DATA_WIDTH`, plus the loader state encoding (IDLE = 0, LOAD = 1, FULL = 2). `sobel_top` and the bench use the same values.
- Sub-module `frame_ram`: `IMG_WIDTH*IMG_HEIGHT` x `DATA_WIDTH`, synchronous write (`we`, `waddr`, `wdata`) and asynchronous read (`raddr`, `rdata`). It has no reset.
- The top level contains the FSM, pointers, address math, the out-of-range mux and the pulse registers.

## Test plan
- **Normal fill:** stream 64 beats with values `row*8+col`, `in_sof` on the first beat and `in_valid` held high. Required: `start` pulses once, in the cycle after beat 63 is accepted, with `frame_ready` rising in the same cycle. Reading (3,5) returns 29, and `in_ready = 0` until release.
- **Backpressure and hold:** while FULL, drive `in_valid = 1` for 10 cycles. Required: no beats accepted, (7,7) still reads 63, no `start` pulse. Then pulse `frame_release`. Required: `in_ready = 1` the next cycle.
- **Missing sof:** in IDLE, send 3 beats with `in_sof = 0`. Required: 3 `sof_err` pulses, state stays IDLE, and a following sof frame loads correctly.
- **Re-sync mid-frame:** after 20 beats, send an `in_sof` beat with value 0xAA, then 63 more beats. Required: 1 `sof_err` pulse, (0,0) reads 0xAA, `start` fires after beat 64 of the new frame only.
- **Reset mid-LOAD:** assert `rst` after 30 beats. Required: immediate return to IDLE with `frame_ready = 0`, no `start`. A full frame after reset then completes normally.
- **Idle gaps and out-of-range:** insert random `in_valid` gaps. Required: stored data identical to the gapless case. Reading with `rd_col` set to an invalid column on a non-power-of-2 `IMG_WIDTH` build (e.g. 6) returns 0.

Source files
------------

// File: rtl/image_frame_loader_pkg.sv
// Shared sizing defaults and loader state encoding for the Sobel front end.
// No logic; constants and a width helper only.
// Imported by the loader RTL, its interface and the bench.
package image_frame_loader_pkg;

    localparam int DEF_IMG_WIDTH  = 8;
    localparam int DEF_IMG_HEIGHT = 8;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    // Address width for n entries; a single-entry dimension still needs a 1-bit field
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_frame_loader_if.sv
// Pixel stream, read port and frame handshake bundle between producer/consumer and loader.
// Wires only, no latency.
// in_valid/in_ready handshake; frame_release hands the held frame back.
interface image_frame_loader_if
    import image_frame_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROW_W      = addr_w(DEF_IMG_HEIGHT),
    parameter int COL_W      = addr_w(DEF_IMG_WIDTH)
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sof;
    logic [ROW_W-1:0]      rd_row;
    logic [COL_W-1:0]      rd_col;
    logic [DATA_WIDTH-1:0] rd_pixel;
    logic                  frame_ready;
    logic                  start;
    logic                  frame_release;
    logic                  sof_err;

    modport master (
        output in_valid, in_data, in_sof, rd_row, rd_col, frame_release,
        input  in_ready, rd_pixel, frame_ready, start, sof_err
    );

    modport slave (
        input  in_valid, in_data, in_sof, rd_row, rd_col, frame_release,
        output in_ready, rd_pixel, frame_ready, start, sof_err
    );

endinterface

// File: rtl/image_frame_loader_ram.sv
// One-frame pixel store: synchronous write port, asynchronous read port, no reset.
// Write visible on rdata the cycle after the write edge; read is combinational.
// No flow control; the loader decides when to write.
module frame_ram #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the accepted pixel
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/image_frame_loader.sv
// Loads one raster-ordered frame, pulses start when complete, serves (row,col) reads until released.
// Pixel readable 1 cycle after its accepting edge; start/frame_ready 1 cycle after the last beat.
// in_ready is low only while a frame is held (state only, never from in_valid).
module image_frame_loader
    import image_frame_loader_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    image_frame_loader_if.slave bus
);

    localparam int COL_W  = addr_w(IMG_WIDTH);
    localparam int ROW_W  = addr_w(IMG_HEIGHT);
    localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_W = addr_w(NPIX);

    logic [1:0]            state;
    logic [ROW_W-1:0]      wr_row;
    logic [COL_W-1:0]      wr_col;
    logic [ROW_W-1:0]      tgt_row;
    logic [COL_W-1:0]      tgt_col;
    logic                  accept;
    logic                  do_write;
    logic                  tgt_last;
    logic                  tgt_col_last;
    logic                  in_range;
    logic [ADDR_W-1:0]     waddr;
    logic [ADDR_W-1:0]     raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  start_q;
    logic                  sof_err_q;

    assign bus.in_ready    = (state != ST_FULL);
    assign bus.frame_ready = (state == ST_FULL);
    assign bus.start       = start_q;
    assign bus.sof_err     = sof_err_q;

    assign accept = bus.in_valid & bus.in_ready;

    // An sof beat always lands at the origin, whether it opens or re-syncs a frame
    assign tgt_row      = bus.in_sof ? '0 : wr_row;
    assign tgt_col      = bus.in_sof ? '0 : wr_col;
    assign tgt_col_last = (32'(tgt_col) == 32'(IMG_WIDTH - 1));
    assign tgt_last     = tgt_col_last && (32'(tgt_row) == 32'(IMG_HEIGHT - 1));

    // Non-sof beats in IDLE are dropped; everything else accepted gets stored
    assign do_write = accept & (bus.in_sof | (state == ST_LOAD));
    assign waddr    = ADDR_W'(32'(tgt_row) * 32'(IMG_WIDTH) + 32'(tgt_col));

    // Out-of-range reads return 0; the RAM is steered to entry 0 so it never sees a wild index
    assign in_range = (32'(bus.rd_row) < 32'(IMG_HEIGHT)) && (32'(bus.rd_col) < 32'(IMG_WIDTH));
    assign raddr    = in_range ? ADDR_W'(32'(bus.rd_row) * 32'(IMG_WIDTH) + 32'(bus.rd_col)) : '0;
    assign bus.rd_pixel = in_range ? rdata : '0;

    frame_ram #(
        .DEPTH      (NPIX),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr (waddr),
        .wdata (bus.in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Frame FSM, write pointers and the start/sof_err pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_row    <= '0;
            wr_col    <= '0;
            start_q   <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            // Missing sof while idle, or an early sof truncating the current frame
            sof_err_q <= accept & (((state == ST_IDLE) & ~bus.in_sof) |
                                   ((state == ST_LOAD) &  bus.in_sof));
            if (state == ST_FULL) begin
                if (bus.frame_release) begin
                    state <= ST_IDLE;
                end
            end else if (do_write) begin
                if (tgt_last) begin
                    state   <= ST_FULL;
                    start_q <= 1'b1;
                    wr_row  <= '0;
                    wr_col  <= '0;
                end else begin
                    state <= ST_LOAD;
                    if (tgt_col_last) begin
                        wr_col <= '0;
                        wr_row <= tgt_row + ROW_W'(1);
                    end else begin
                        wr_col <= tgt_col + COL_W'(1);
                        wr_row <= tgt_row;
                    end
                end
            end
        end
    end

endmodule
